// File: rtl/chronos.sv
// Shared task/slot/timestamp types for the dequeue side of the task queue.
package chronos;

  localparam int N_TYPES_DEFAULT = 4;
  localparam int TS_W            = 32;

  typedef logic [TS_W-1:0] ts_t;
  typedef logic [7:0]      cq_slice_slot_t;

  typedef struct packed {
    ts_t         ts;
    logic [31:0] hint;
    logic [31:0] arg;
  } task_t;

endpackage

// File: rtl/ts_min_select.sv
// Picks the valid candidate with the smallest timestamp; ties go to the first
// candidate at or after rr_ptr (TIE_RR=1) or to the lowest index (TIE_RR=0).
module ts_min_select
  import chronos::*;
#(
  parameter int N      = N_TYPES_DEFAULT,
  parameter bit TIE_RR = 1'b1,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  ts_t           ts [N],
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output ts_t           min_ts
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    min_ts = '1;
    for (int k = 0; k < N; k++) begin
      int            j;
      logic [IW-1:0] jw;
      j = (TIE_RR ? int'(rr_ptr) : 0) + k;
      if (j >= N) j = j - N;
      jw = IW'(j);
      // Strict less-than keeps the earliest candidate in scan order on ties.
      if (valid[jw] && (!found || ts[jw] < min_ts)) begin
        found  = 1'b1;
        idx    = jw;
        min_ts = ts[jw];
      end
    end
  end

endmodule

// File: rtl/deq_type_arbiter.sv
// Arbitrates per-type dequeue FIFO heads by minimum timestamp, issues one task
// at a time to the conflict checker and routes its verdict back to the owner.
module deq_type_arbiter
  import chronos::*;
#(
  parameter int N_TYPES = N_TYPES_DEFAULT,
  parameter bit TIE_RR  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_TYPES-1:0]   s_rvalid,
  input  task_t                s_rdata [N_TYPES],
  input  cq_slice_slot_t       s_rslot [N_TYPES],
  output logic                 s_rresp,
  output logic [N_TYPES-1:0]   s_rresp_valid,
  input  logic [N_TYPES-1:0]   type_enable,
  output logic                 m_valid,
  input  logic                 m_ready,
  output task_t                m_task,
  output cq_slice_slot_t       m_slot,
  input  logic                 m_resp_valid,
  input  logic                 m_resp,
  output ts_t                  lvt,
  output logic                 idle
);

  localparam int IW  = (N_TYPES > 1) ? $clog2(N_TYPES) : 1;
  localparam int LIW = $clog2(N_TYPES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t           state;
  logic [IW-1:0]    grant;
  logic [IW-1:0]    rr_ptr;
  task_t            task_q;
  cq_slice_slot_t   slot_q;

  logic [N_TYPES-1:0] cand;
  logic               busy;
  logic               resp_fire;
  ts_t                head_ts [N_TYPES];
  ts_t                lvt_ts  [N_TYPES+1];

  logic               sel_found;
  logic [IW-1:0]      sel_idx;
  ts_t                unused_sel_ts;
  logic               lvt_found;
  logic [LIW-1:0]     unused_lvt_idx;
  ts_t                lvt_min;

  assign cand      = s_rvalid & type_enable;
  assign busy      = (state != IDLE);
  assign resp_fire = (state == WAIT_RESP) && m_resp_valid;

  always_comb begin
    for (int i = 0; i < N_TYPES; i++) begin
      head_ts[i] = s_rdata[i].ts;
      lvt_ts[i]  = s_rdata[i].ts;
    end
    lvt_ts[N_TYPES] = task_q.ts;
  end

  ts_min_select #(.N(N_TYPES), .TIE_RR(TIE_RR)) u_grant_sel (
    .valid  (cand),
    .ts     (head_ts),
    .rr_ptr (rr_ptr),
    .found  (sel_found),
    .idx    (sel_idx),
    .min_ts (unused_sel_ts)
  );

  // The outstanding task holds back lvt until its verdict returns.
  ts_min_select #(.N(N_TYPES + 1), .TIE_RR(1'b0)) u_lvt_sel (
    .valid  ({busy, cand}),
    .ts     (lvt_ts),
    .rr_ptr ('0),
    .found  (lvt_found),
    .idx    (unused_lvt_idx),
    .min_ts (lvt_min)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      task_q  <= '0;
      slot_q  <= '0;
      m_valid <= 1'b0;
      lvt     <= '1;
    end else begin
      lvt <= lvt_found ? lvt_min : '1;
      case (state)
        IDLE: if (sel_found) begin
          grant   <= sel_idx;
          task_q  <= s_rdata[sel_idx];
          slot_q  <= s_rslot[sel_idx];
          m_valid <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: if (m_ready) begin
          m_valid <= 1'b0;
          state   <= WAIT_RESP;
        end
        WAIT_RESP: if (m_resp_valid) begin
          rr_ptr <= (grant == IW'(N_TYPES - 1)) ? '0 : grant + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_rresp_valid = '0;
    if (resp_fire) s_rresp_valid[grant] = 1'b1;
  end

  assign s_rresp = resp_fire & m_resp;
  assign m_task  = task_q;
  assign m_slot  = slot_q;
  assign idle    = (state == IDLE) && !(|cand);

endmodule

// File: tb/tb_deq_type_arbiter.sv
// Directed bench for deq_type_arbiter: min-ts grant, round-robin ties, stall,
// reject routing, disabled types, lvt and reset mid-transaction.
module tb_deq_type_arbiter;
  import chronos::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   s_rvalid;
  task_t          s_rdata [N];
  cq_slice_slot_t s_rslot [N];
  logic           s_rresp;
  logic [N-1:0]   s_rresp_valid;
  logic [N-1:0]   type_enable;
  logic           m_valid;
  logic           m_ready;
  task_t          m_task;
  cq_slice_slot_t m_slot;
  logic           m_resp_valid;
  logic           m_resp;
  ts_t            lvt;
  logic           idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  deq_type_arbiter #(.N_TYPES(N), .TIE_RR(1'b1)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_rvalid      (s_rvalid),
    .s_rdata       (s_rdata),
    .s_rslot       (s_rslot),
    .s_rresp       (s_rresp),
    .s_rresp_valid (s_rresp_valid),
    .type_enable   (type_enable),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_task        (m_task),
    .m_slot        (m_slot),
    .m_resp_valid  (m_resp_valid),
    .m_resp        (m_resp),
    .lvt           (lvt),
    .idle          (idle)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ts(input ts_t t0, input ts_t t1, input ts_t t2, input ts_t t3);
    s_rdata[0].ts = t0;
    s_rdata[1].ts = t1;
    s_rdata[2].ts = t2;
    s_rdata[3].ts = t3;
  endtask

  // Called at a falling edge with the FSM idle and the heads already driven;
  // m_ready is high so the task is taken on its first ISSUE cycle.
  task automatic do_txn(input int idx, input ts_t ts, input logic resp, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".m_valid"}, 64'(m_valid), 64'd1);
    check({tag, ".ts"},      64'(m_task.ts), 64'(ts));
    check({tag, ".slot"},    64'(m_slot), 64'(8'h10 + idx));
    @(negedge clk);
    check({tag, ".wait_mvalid"}, 64'(m_valid), 64'd0);
    check({tag, ".pre_strobe"},  64'(s_rresp_valid), 64'd0);
    m_resp_valid = 1'b1;
    m_resp       = resp;
    #1;
    check({tag, ".strobe"}, 64'(s_rresp_valid), 64'(oh));
    check({tag, ".resp"},   64'(s_rresp), 64'(resp));
    @(negedge clk);
    m_resp_valid = 1'b0;
    m_resp       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn         = 1'b0;
    s_rvalid     = '0;
    type_enable  = '1;
    m_ready      = 1'b1;
    m_resp_valid = 1'b0;
    m_resp       = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_rdata[i]     = '0;
      s_rdata[i].arg = 32'hA000 + i;
      s_rslot[i]     = cq_slice_slot_t'(8'h10 + i);
    end

    // Reset state, including a verdict strobe that must be ignored.
    #12;
    check("rst.m_valid", 64'(m_valid), 64'd0);
    check("rst.s_rresp", 64'(s_rresp), 64'd0);
    check("rst.idle",    64'(idle), 64'd1);
    check("rst.lvt",     64'(lvt), 64'hFFFF_FFFF);
    m_resp_valid = 1'b1;
    #1;
    check("rst.strobe", 64'(s_rresp_valid), 64'd0);
    m_resp_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Minimum timestamp wins.
    set_ts(40, 10, 30, 20);
    s_rvalid = 4'hF;
    #1;
    check("s1.idle", 64'(idle), 64'd0);
    do_txn(1, 10, 1'b0, "s1");

    // Equal timestamps rotate from rr_ptr=0 and wrap.
    rstn = 1'b0;
    set_ts(5, 5, 5, 5);
    #1;
    rstn = 1'b1;
    do_txn(0, 5, 1'b0, "s2.g0");
    do_txn(1, 5, 1'b0, "s2.g1");
    do_txn(2, 5, 1'b0, "s2.g2");
    do_txn(3, 5, 1'b0, "s2.g3");
    do_txn(0, 5, 1'b0, "s2.wrap");

    // Checker stalls seven cycles; latched task holds while heads move.
    set_ts(9, 3, 9, 9);
    m_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("s3.m_valid", 64'(m_valid), 64'd1);
      check("s3.ts",      64'(m_task.ts), 64'd3);
      check("s3.slot",    64'(m_slot), 64'h11);
      if (k == 0) check("s3.lvt_latched", 64'(lvt), 64'd3);
      if (k == 1) begin
        s_rvalid[1]    = 1'b0;
        s_rdata[1].ts  = 1;
      end
      if (k == 2) s_rdata[2].ts = 2;
      if (k == 4) check("s3.lvt_head", 64'(lvt), 64'd2);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("s3.wait_mvalid", 64'(m_valid), 64'd0);
    m_resp_valid = 1'b1;
    m_resp       = 1'b0;
    #1;
    check("s3.strobe", 64'(s_rresp_valid), 64'b0010);
    check("s3.resp",   64'(s_rresp), 64'd0);
    @(negedge clk);
    m_resp_valid = 1'b0;
    s_rvalid     = 4'hF;
    set_ts(7, 7, 7, 7);
    #1;
    check("s3.single", 64'(s_rresp_valid), 64'd0);

    // Reject routed to grant 2, then a spurious verdict in IDLE.
    do_txn(2, 7, 1'b1, "s4");
    s_rvalid     = '0;
    m_resp_valid = 1'b1;
    m_resp       = 1'b1;
    #1;
    check("s4.spur_strobe", 64'(s_rresp_valid), 64'd0);
    check("s4.spur_resp",   64'(s_rresp), 64'd0);
    check("s4.spur_idle",   64'(idle), 64'd1);
    @(negedge clk);
    check("s4.spur_mvalid", 64'(m_valid), 64'd0);
    check("s4.spur_idle2",  64'(idle), 64'd1);
    m_resp_valid = 1'b0;
    m_resp       = 1'b0;

    // Disabled type 0 is never granted despite the smallest timestamp.
    type_enable = 4'b1110;
    set_ts(1, 20, 30, 40);
    s_rvalid = 4'hF;
    #1;
    check("s5.idle", 64'(idle), 64'd0);
    do_txn(1, 20, 1'b0, "s5.g1");
    s_rvalid[1] = 1'b0;
    do_txn(2, 30, 1'b0, "s5.g2");
    s_rvalid[2] = 1'b0;
    do_txn(3, 40, 1'b0, "s5.g3");
    s_rvalid[3] = 1'b0;
    #1;
    check("s5.idle_end", 64'(idle), 64'd1);
    repeat (2) @(negedge clk);
    check("s5.no_issue", 64'(m_valid), 64'd0);
    check("s5.lvt",      64'(lvt), 64'hFFFF_FFFF);

    // Reset while waiting for a verdict abandons the task.
    type_enable = '1;
    set_ts(4, 4, 4, 4);
    s_rvalid = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("s6.m_valid", 64'(m_valid), 64'd1);
    @(negedge clk);
    check("s6.wait_mvalid", 64'(m_valid), 64'd0);
    rstn         = 1'b0;
    m_resp_valid = 1'b1;
    m_resp       = 1'b1;
    #1;
    check("s6.rst_strobe", 64'(s_rresp_valid), 64'd0);
    check("s6.rst_resp",   64'(s_rresp), 64'd0);
    check("s6.rst_lvt",    64'(lvt), 64'hFFFF_FFFF);
    @(negedge clk);
    check("s6.rst_strobe2", 64'(s_rresp_valid), 64'd0);
    check("s6.rst_mvalid",  64'(m_valid), 64'd0);
    m_resp_valid = 1'b0;
    m_resp       = 1'b0;
    rstn         = 1'b1;
    do_txn(0, 4, 1'b0, "s6.after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
